// File: rtl/nn_pe_pkg.sv
// ---------------------------------------------------------------------------
// nn_pe_pkg
// Shared definitions for the neuron MAC processing element:
//   - activation-mode encodings (identity / ReLU / leaky ReLU / reserved)
//   - FSM state encoding for the vector sequencer
//   - leaky-ReLU shift amount
//   - a generic signed saturation helper used by the round/activate stage
// ---------------------------------------------------------------------------
package nn_pe_pkg;

    localparam logic [1:0] ACT_IDENT = 2'b00;
    localparam logic [1:0] ACT_RELU  = 2'b01;
    localparam logic [1:0] ACT_LEAKY = 2'b10;
    localparam logic [1:0] ACT_RSVD  = 2'b11;  // behaves as identity

    localparam int unsigned LEAKY_SHIFT = 3;

    // Working width of the saturation helper; any rounded accumulator value
    // (ACC_W + 1 - FRAC_W significant bits) must fit in it.
    localparam int unsigned SAT_MAX_W = 64;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDrain,
        StHold
    } pe_state_e;

    // Clip x to the signed range of a w-bit two's-complement number.
    function automatic logic signed [SAT_MAX_W-1:0] sat_to_width(
        input logic signed [SAT_MAX_W-1:0] x,
        input int unsigned                 w
    );
        logic signed [SAT_MAX_W-1:0] hi;
        logic signed [SAT_MAX_W-1:0] lo;
        hi = (SAT_MAX_W'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/pe_round_act.sv
// ---------------------------------------------------------------------------
// pe_round_act
// Combinational output stage: rounds the full-precision total to the output
// Q format (half toward +inf), saturates to DATA_W and applies the selected
// activation function.
// Ports:
//   i_t     ACC_W   total (accumulator + last lane sum + aligned bias), signed
//   i_mode  2       activation mode
//   o_data  DATA_W  activated, saturated result
//   o_sat   1       set when the rounded value had to be clipped
// ---------------------------------------------------------------------------
module pe_round_act
    import nn_pe_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned ACC_W  = 40
) (
    input  logic [ACC_W-1:0]  i_t,
    input  logic [1:0]        i_mode,
    output logic [DATA_W-1:0] o_data,
    output logic              o_sat
);

    localparam logic signed [ACC_W:0] RND_HALF = (ACC_W + 1)'(1) <<< (FRAC_W - 1);

    logic signed [ACC_W:0]         w_rnd;
    logic signed [ACC_W:0]         w_shr;
    logic signed [SAT_MAX_W-1:0]   w_wide;
    logic signed [SAT_MAX_W-1:0]   w_clip;
    logic signed [DATA_W-1:0]      w_sat_val;
    logic signed [DATA_W-1:0]      w_leaky;

    always_comb begin
        // One guard bit so the rounding add cannot wrap.
        w_rnd     = (ACC_W + 1)'($signed(i_t)) + RND_HALF;
        w_shr     = w_rnd >>> FRAC_W;
        w_wide    = SAT_MAX_W'(w_shr);
        w_clip    = sat_to_width(w_wide, DATA_W);
        o_sat     = (w_clip != w_wide);
        w_sat_val = w_clip[DATA_W-1:0];
        w_leaky   = w_sat_val >>> LEAKY_SHIFT;

        o_data = w_sat_val;
        case (i_mode)
            ACT_RELU:  if (w_sat_val[DATA_W-1]) o_data = '0;
            ACT_LEAKY: if (w_sat_val[DATA_W-1]) o_data = w_leaky;
            default:   o_data = w_sat_val;
        endcase
    end

endmodule

// File: rtl/neuron_mac_pe.sv
// ---------------------------------------------------------------------------
// neuron_mac_pe
// Streaming neuron MAC: accumulates LANES activation*weight products per beat
// over a multi-beat vector, adds a bias, rounds/saturates to DATA_W and applies
// an activation. Three-stage pipeline (products, lane sum, accumulate/output).
// Ports:
//   clk, rst               clock; synchronous active-low reset
//   in_valid/in_ready      beat handshake; in_last marks the final beat
//   act_i, wt_i            LANES packed signed operands, lane k at [k*DATA_W +: DATA_W]
//   bias_i, act_mode       sampled on the first beat of a vector
//   out_valid/out_ready    result handshake
//   out_data, out_sat      activated result and saturation flag
//   out_beats              beats accepted for the result (sticks at max)
// ---------------------------------------------------------------------------
module neuron_mac_pe
    import nn_pe_pkg::*;
#(
    parameter int unsigned LANES  = 4,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned ACC_W  = 40
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic [LANES*DATA_W-1:0] act_i,
    input  logic [LANES*DATA_W-1:0] wt_i,
    input  logic [DATA_W-1:0]       bias_i,
    input  logic [1:0]              act_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_sat,
    output logic [CNT_W-1:0]        out_beats
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned SUM_W  = PROD_W + $clog2(LANES);

    pe_state_e                 r_state;

    // Stage 1: per-lane products
    logic signed [PROD_W-1:0]  r_prod [LANES];
    logic                      r_v1;
    logic                      r_last1;
    // Stage 2: lane sum
    logic signed [SUM_W-1:0]   r_sum;
    logic                      r_v2;
    logic                      r_last2;

    logic signed [ACC_W-1:0]   r_acc;
    logic signed [DATA_W-1:0]  r_bias;
    logic [1:0]                r_mode;
    logic [CNT_W-1:0]          r_beats;

    logic                      r_out_valid;
    logic [DATA_W-1:0]         r_out_data;
    logic                      r_out_sat;
    logic [CNT_W-1:0]          r_out_beats;

    logic                      w_accept;
    logic signed [PROD_W-1:0]  w_prod [LANES];
    logic signed [SUM_W-1:0]   w_sum;
    logic signed [ACC_W-1:0]   w_t;
    logic [DATA_W-1:0]         w_data;
    logic                      w_sat;

    assign in_ready = rst & ((r_state == StIdle) | (r_state == StAccum));
    assign w_accept = in_valid & in_ready;

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign out_beats = r_out_beats;

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            w_prod[k] = PROD_W'($signed(act_i[k*DATA_W +: DATA_W]))
                      * PROD_W'($signed(wt_i[k*DATA_W +: DATA_W]));
        end
    end

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            w_sum = w_sum + SUM_W'(r_prod[k]);
        end
    end

    // Total seen by the output stage: running sum, final beat, bias aligned
    // to the product fraction (2*FRAC_W) by shifting it up FRAC_W bits.
    assign w_t = r_acc + ACC_W'(r_sum) + (ACC_W'(r_bias) <<< FRAC_W);

    pe_round_act #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W)
    ) u_round_act (
        .i_t    (w_t),
        .i_mode (r_mode),
        .o_data (w_data),
        .o_sat  (w_sat)
    );

    // Datapath pipeline registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_v1    <= 1'b0;
            r_last1 <= 1'b0;
            r_v2    <= 1'b0;
            r_last2 <= 1'b0;
            r_sum   <= '0;
            for (int k = 0; k < LANES; k++) begin
                r_prod[k] <= '0;
            end
        end else begin
            r_v1    <= w_accept;
            r_last1 <= w_accept & in_last;
            if (w_accept) begin
                for (int k = 0; k < LANES; k++) begin
                    r_prod[k] <= w_prod[k];
                end
            end
            r_v2    <= r_v1;
            r_last2 <= r_last1;
            if (r_v1) begin
                r_sum <= w_sum;
            end
        end
    end

    // Sequencer, accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= StIdle;
            r_acc       <= '0;
            r_bias      <= '0;
            r_mode      <= ACT_IDENT;
            r_beats     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
            r_out_beats <= '0;
        end else begin
            if (w_accept && (r_beats != '1)) begin
                r_beats <= r_beats + CNT_W'(1);
            end

            // Stage 3: the final beat writes the output instead of the accumulator.
            if (r_v2) begin
                if (r_last2) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_data;
                    r_out_sat   <= w_sat;
                    r_out_beats <= r_beats;
                end else begin
                    r_acc <= r_acc + ACC_W'(r_sum);
                end
            end

            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_bias  <= $signed(bias_i);
                        r_mode  <= act_mode;
                        r_state <= in_last ? StDrain : StAccum;
                    end
                end
                StAccum: begin
                    if (w_accept && in_last) begin
                        r_state <= StDrain;
                    end
                end
                StDrain: begin
                    if (r_v2 && r_last2) begin
                        r_state <= StHold;
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_beats     <= '0;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_pe.sv
module tb_neuron_mac_pe;

    localparam int LANES  = 4;
    localparam int DATA_W = 16;
    localparam int FRAC_W = 8;
    localparam int CNT_W  = 8;
    localparam int ACC_W  = 40;
    localparam int MAXB   = 300;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic                    in_last = 1'b0;
    logic [LANES*DATA_W-1:0] act_i = '0;
    logic [LANES*DATA_W-1:0] wt_i = '0;
    logic [DATA_W-1:0]       bias_i = '0;
    logic [1:0]              act_mode = 2'b00;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [DATA_W-1:0]       out_data;
    logic                    out_sat;
    logic [CNT_W-1:0]        out_beats;

    logic [15:0] va [MAXB][LANES];
    logic [15:0] vw [MAXB][LANES];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    neuron_mac_pe #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .CNT_W  (CNT_W),
        .ACC_W  (ACC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .act_i     (act_i),
        .wt_i      (wt_i),
        .bias_i    (bias_i),
        .act_mode  (act_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_beats (out_beats)
    );

    // Reference: exact real-valued arithmetic on integers scaled by 2^16.
    function automatic void model(input int nb, input logic [15:0] bias, input logic [1:0] mode,
                                  output logic [15:0] d, output logic s, output logic [7:0] beats);
        longint t;
        longint r;
        t = longint'($signed(bias)) * 256;
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < LANES; k++) begin
                t += longint'($signed(va[b][k])) * longint'($signed(vw[b][k]));
            end
        end
        r = t + 128;
        r = (r >= 0) ? r / 256 : -((-r + 255) / 256);
        s = 1'b0;
        if (r > 32767) begin r = 32767; s = 1'b1; end
        else if (r < -32768) begin r = -32768; s = 1'b1; end
        if (mode == 2'b01 && r < 0) r = 0;
        if (mode == 2'b10 && r < 0) r = -((-r + 7) / 8);
        d = 16'(r);
        beats = (nb > 255) ? 8'd255 : 8'(nb);
    endfunction

    task automatic set_beat(input int b, input logic last, input logic [15:0] bias,
                            input logic [1:0] mode);
        in_valid = 1'b1;
        in_last  = last;
        bias_i   = bias;
        act_mode = mode;
        for (int k = 0; k < LANES; k++) begin
            act_i[k*DATA_W +: DATA_W] = va[b][k];
            wt_i[k*DATA_W +: DATA_W]  = vw[b][k];
        end
    endtask

    // Drives nb beats; returns with the last beat just accepted (after posedge).
    task automatic send_vector(input int nb, input logic [15:0] bias, input logic [1:0] mode,
                               output int stalls);
        int g;
        stalls = 0;
        for (int b = 0; b < nb; b++) begin
            @(negedge clk);
            set_beat(b, (b == nb - 1), bias, mode);
            g = 0;
            while (!in_ready && g < 50) begin
                @(negedge clk);
                g++;
            end
            stalls += g;
            if (g >= 50) begin
                n_checks++;
                n_errors++;
                $display("FAIL accept_timeout: beat %0d not accepted within %0d cycles", b, g);
            end
            @(posedge clk);
        end
    endtask

    // Counts edges from last-beat acceptance until out_valid; notes any in_ready seen.
    task automatic wait_result(output int lat, output logic rdy_seen);
        lat = 0;
        rdy_seen = 1'b0;
        do begin
            @(negedge clk);
            if (lat == 0) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            if (in_ready) rdy_seen = 1'b1;
            lat++;
        end while (!out_valid && lat < 20);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic fill_lanes(input int b, input logic [15:0] a0, input logic [15:0] a1,
                              input logic [15:0] a2, input logic [15:0] a3,
                              input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] w2, input logic [15:0] w3);
        va[b][0] = a0; va[b][1] = a1; va[b][2] = a2; va[b][3] = a3;
        vw[b][0] = w0; vw[b][1] = w1; vw[b][2] = w2; vw[b][3] = w3;
    endtask

    // Runs one vector and checks data/sat/beats/latency against given values.
    task automatic run_and_check(input string name, input int nb, input logic [15:0] bias,
                                 input logic [1:0] mode, input logic [15:0] exp_d,
                                 input logic exp_s, input logic [7:0] exp_b);
        int st;
        int lat;
        logic rdy;
        send_vector(nb, bias, mode, st);
        wait_result(lat, rdy);
        n_checks++;
        if (lat !== 3) begin
            n_errors++;
            $display("FAIL %s latency: got %0d edges, want 3", name, lat);
        end
        n_checks++;
        if (out_data !== exp_d) begin
            n_errors++;
            $display("FAIL %s data: got %h, want %h", name, out_data, exp_d);
        end
        n_checks++;
        if (out_sat !== exp_s) begin
            n_errors++;
            $display("FAIL %s sat: got %b, want %b", name, out_sat, exp_s);
        end
        n_checks++;
        if (out_beats !== exp_b) begin
            n_errors++;
            $display("FAIL %s beats: got %0d, want %0d", name, out_beats, exp_b);
        end
        handshake();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset in_ready: got %b, want 0", in_ready);
        end
        n_checks++;
        if ({out_valid, out_data, out_sat, out_beats} !== '0) begin
            n_errors++;
            $display("FAIL reset outputs: got v=%b d=%h s=%b b=%0d, want all 0",
                     out_valid, out_data, out_sat, out_beats);
        end
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset release in_ready: got %b, want 1", in_ready);
        end
    endtask

    task automatic test_single_beat();
        fill_lanes(0, 16'h0100, 16'h0100, 16'h0100, 16'h0100,
                   16'h0100, 16'h0200, 16'hFF80, 16'h0080);
        run_and_check("single_relu", 1, 16'h0000, 2'b01, 16'h0300, 1'b0, 8'd1);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL single_after_hs: got valid=%b ready=%b, want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_activations();
        fill_lanes(0, 16'h0100, 16'h0100, 16'h0100, 16'h0100,
                   16'hFF00, 16'hFE00, 16'h0080, 16'hFF80);
        run_and_check("neg_ident", 1, 16'h0000, 2'b00, 16'hFD00, 1'b0, 8'd1);
        run_and_check("neg_relu", 1, 16'h0000, 2'b01, 16'h0000, 1'b0, 8'd1);
        run_and_check("neg_leaky", 1, 16'h0000, 2'b10, 16'hFFA0, 1'b0, 8'd1);
        run_and_check("neg_rsvd", 1, 16'h0000, 2'b11, 16'hFD00, 1'b0, 8'd1);
        fill_lanes(0, 16'h0001, 16'h0000, 16'h0000, 16'h0000,
                   16'h0080, 16'h0000, 16'h0000, 16'h0000);
        run_and_check("half_round", 1, 16'h0000, 2'b00, 16'h0001, 1'b0, 8'd1);
    endtask

    task automatic test_back_to_back();
        int st;
        int lat;
        logic rdy;
        fill_lanes(0, 16'h0100, 16'h0100, 16'h0100, 16'h0100,
                   16'h0100, 16'h0000, 16'h0000, 16'h0000);
        fill_lanes(1, 16'h0200, 16'h0000, 16'h0000, 16'h0000,
                   16'h0080, 16'h0000, 16'h0000, 16'h0000);
        fill_lanes(2, 16'h0100, 16'h0100, 16'h0100, 16'h0100,
                   16'h0040, 16'h0040, 16'h0040, 16'h0040);
        send_vector(3, 16'h0080, 2'b00, st);
        wait_result(lat, rdy);
        n_checks++;
        if (st !== 0) begin
            n_errors++;
            $display("FAIL b2b stalls: got %0d, want 0", st);
        end
        n_checks++;
        if (rdy !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b in_ready during drain: got 1, want 0");
        end
        n_checks++;
        if (lat !== 3 || out_data !== 16'h0380 || out_beats !== 8'd3 || out_sat !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b result: got lat=%0d d=%h b=%0d s=%b, want 3/0380/3/0",
                     lat, out_data, out_beats, out_sat);
        end
        handshake();
    endtask

    task automatic test_saturation();
        fill_lanes(0, 16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00,
                   16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00);
        run_and_check("sat_pos", 1, 16'h0000, 2'b00, 16'h7FFF, 1'b1, 8'd1);
        fill_lanes(0, 16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00,
                   16'h8100, 16'h8100, 16'h8100, 16'h8100);
        run_and_check("sat_neg", 1, 16'h0000, 2'b00, 16'h8000, 1'b1, 8'd1);
        run_and_check("sat_neg_relu", 1, 16'h0000, 2'b01, 16'h0000, 1'b1, 8'd1);
    endtask

    task automatic test_backpressure();
        int st;
        int lat;
        logic rdy;
        fill_lanes(0, 16'h0300, 16'h0000, 16'h0000, 16'h0000,
                   16'h0100, 16'h0000, 16'h0000, 16'h0000);
        send_vector(1, 16'h0000, 2'b00, st);
        wait_result(lat, rdy);
        fill_lanes(0, 16'h0100, 16'h0000, 16'h0000, 16'h0000,
                   16'h0100, 16'h0000, 16'h0000, 16'h0000);
        set_beat(0, 1'b1, 16'h0000, 2'b00);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 16'h0300 || out_sat !== 1'b0 ||
                out_beats !== 8'd1 || in_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL hold_stable[%0d]: got v=%b d=%h s=%b b=%0d rdy=%b, want 1/0300/0/1/0",
                         c, out_valid, out_data, out_sat, out_beats, in_ready);
            end
        end
        handshake();
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL hold_release in_ready: got %b, want 1", in_ready);
        end
        @(posedge clk);
        wait_result(lat, rdy);
        n_checks++;
        if (lat !== 3 || out_data !== 16'h0100 || out_beats !== 8'd1) begin
            n_errors++;
            $display("FAIL hold_next result: got lat=%0d d=%h b=%0d, want 3/0100/1",
                     lat, out_data, out_beats);
        end
        handshake();
    endtask

    task automatic test_mid_reset();
        for (int b = 0; b < 3; b++) begin
            fill_lanes(b, 16'h0400, 16'h0200, 16'h0100, 16'h0300,
                       16'h0100, 16'h0100, 16'h0100, 16'h0100);
        end
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            set_beat(b, 1'b0, 16'h0100, 2'b00);
            @(posedge clk);
        end
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst in_ready: got %b, want 0", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_data, out_sat, out_beats} !== '0) begin
            n_errors++;
            $display("FAIL midrst outputs: got v=%b d=%h s=%b b=%0d, want all 0",
                     out_valid, out_data, out_sat, out_beats);
        end
        rst = 1'b1;
        in_valid = 1'b0;
        fill_lanes(0, 16'h0100, 16'h0000, 16'h0000, 16'h0000,
                   16'h0100, 16'h0000, 16'h0000, 16'h0000);
        run_and_check("midrst_next", 1, 16'h0000, 2'b00, 16'h0100, 1'b0, 8'd1);
    endtask

    task automatic test_beat_saturate();
        for (int b = 0; b < 260; b++) begin
            fill_lanes(b, 16'h0001, 16'h0001, 16'h0001, 16'h0001,
                       16'h0001, 16'h0001, 16'h0001, 16'h0001);
        end
        // 1040 * 2^-16 total, rounds to 4 * 2^-8
        run_and_check("beat_sat", 260, 16'h0000, 2'b00, 16'h0004, 1'b0, 8'd255);
    endtask

    task automatic test_random();
        int nb;
        logic [15:0] bias;
        logic [1:0] mode;
        logic [15:0] ed;
        logic es;
        logic [7:0] eb;
        for (int v = 0; v < 30; v++) begin
            nb   = $urandom_range(1, 6);
            mode = 2'($urandom_range(0, 3));
            for (int b = 0; b < nb; b++) begin
                for (int k = 0; k < LANES; k++) begin
                    if (v % 3 == 0) begin
                        va[b][k] = 16'($urandom);
                        vw[b][k] = 16'($urandom);
                    end else begin
                        va[b][k] = 16'($urandom_range(0, 1023)) - 16'd512;
                        vw[b][k] = 16'($urandom_range(0, 1023)) - 16'd512;
                    end
                end
            end
            bias = (v % 3 == 0) ? 16'($urandom) : 16'($urandom_range(0, 1023)) - 16'd512;
            model(nb, bias, mode, ed, es, eb);
            run_and_check($sformatf("rand%0d", v), nb, bias, mode, ed, es, eb);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_beat();
        test_activations();
        test_back_to_back();
        test_saturation();
        test_backpressure();
        test_mid_reset();
        test_beat_saturate();
        test_random();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
